// File: rtl/burst_line_adapter_pkg.sv
// Shared types and width helpers for the cache-line to memory-burst adapter.
package burst_line_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } bla_state_e;

  // ceil(log2(n)); 0 for n <= 1, used for beat-index and byte-offset widths
  function automatic int bla_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/burst_line_adapter.sv
// Moves one cache line to/from memory as LINE_W/BEAT_W beats, optionally starting
// at the critical beat and wrapping around the line.
module burst_line_adapter
  import burst_line_adapter_pkg::*;
#(
  parameter int LINE_W     = 256,
  parameter int BEAT_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int CRIT_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int LINE_OFF = bla_clog2(LINE_W / 8);
  localparam int BEAT_OFF = bla_clog2(BEAT_W / 8);
  localparam int IDX_W    = (BEATS > 1) ? bla_clog2(BEATS) : 1;
  localparam int ALIGN_SH = (CRIT_FIRST != 0) ? BEAT_OFF : LINE_OFF;
  localparam logic [IDX_W-1:0]  LAST_CNT   = IDX_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_SH) - ADDR_W'(1));

  if ((LINE_W % BEAT_W) != 0) begin : g_chk_mult
    $error("LINE_W must be a multiple of BEAT_W");
  end
  if (((LINE_W & (LINE_W - 1)) != 0) || ((BEAT_W & (BEAT_W - 1)) != 0)) begin : g_chk_pow2
    $error("LINE_W and BEAT_W must be powers of two");
  end
  if (BEAT_W < 8) begin : g_chk_beat
    $error("BEAT_W must be at least 8");
  end

  bla_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx;

  // Natural wrap of the IDX_W-bit sum gives (start + cnt) mod BEATS
  assign idx = start_q + cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (line_write || line_read) begin
          start_d = (CRIT_FIRST != 0 && BEATS > 1) ? IDX_W'(line_addr >> BEAT_OFF) : '0;
          addr_d  = line_addr & ALIGN_MASK;
          state_d = line_write ? WRITE : READ;
          if (line_write) buf_d = line_wdata;
        end
      end
      READ: begin
        if (mem_resp) begin
          buf_d[idx*BEAT_W +: BEAT_W] = mem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      WRITE: begin
        if (mem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  // Memory side is decoded purely from registered state
  assign mem_read   = (state_q == READ);
  assign mem_write  = (state_q == WRITE);
  assign line_resp  = (state_q == DONE);
  assign mem_addr   = addr_q;
  assign line_rdata = buf_q;
  assign mem_wdata  = mem_write ? buf_q[idx*BEAT_W +: BEAT_W] : '0;

endmodule
